// File: rtl/sfr_pkg.sv
// Shared types and constants for the SFR bus initiator slice.
package sfr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RSP  = 2'd3
  } sfr_state_e;

  // Register map of the SFR block behind the bus
  localparam logic [31:0] SFR_CONTROL  = 32'h0000_0000;
  localparam logic [31:0] SFR_INTR_STS = 32'h0000_0004;
  localparam logic [31:0] SFR_INTR_MSK = 32'h0000_0008;

  localparam int unsigned TIMEOUT_CYCLES_DFLT = 8;

  // Word accesses only; anything else is rejected without a bus cycle
  function automatic logic is_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/sfr_bus_initiator_if.sv
// Command/response handshake bundle between a client and the initiator.
interface sfr_bus_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrobe;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_write;
  logic        rsp_timeout;
  logic        rsp_err;

  // Client side: issues commands, consumes responses
  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrobe, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_write, rsp_timeout, rsp_err
  );

  // Initiator side
  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrobe, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_write, rsp_timeout, rsp_err
  );
endinterface

// File: rtl/sfr_timeout_cnt.sv
// WAIT-state cycle counter; expired flags the last allowed WAIT cycle.
module sfr_timeout_cnt #(
  parameter int unsigned LIMIT = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] cnt;

  // Cleared on the way into WAIT, advances once per WAIT cycle without ack
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + 8'd1;
  end

  // cnt holds completed WAIT cycles, so LIMIT-1 means this is cycle LIMIT
  assign expired = enable && (cnt == 8'(LIMIT - 1));

endmodule

// File: rtl/sfr_bus_initiator.sv
// Single-outstanding SFR bus initiator: command in, one strobe, ack/timeout, response out.
module sfr_bus_initiator
  import sfr_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
) (
  input  logic                clk,
  input  logic                reset_n,
  sfr_bus_initiator_if.slave  cmd_rsp,
  output logic                o_wr_en,
  output logic                o_rd_en,
  output logic [31:0]         o_waddr,
  output logic [31:0]         o_raddr,
  output logic [31:0]         o_wdata,
  output logic [3:0]          o_wstrobe,
  input  logic                i_wready,
  input  logic                i_rvalid,
  input  logic [31:0]         i_rdata,
  output logic                busy
);

  sfr_state_e  state_q, state_d;
  logic        accept, aligned, ack, expired, cnt_clr, cnt_en;
  logic        cmd_ready_c, rsp_valid_c, wr_en_c, rd_en_c, busy_c;
  logic [31:0] waddr_q, raddr_q, wdata_q, rdata_q;
  logic [3:0]  wstrobe_q;
  logic        write_q, timeout_q, err_q;

  assign aligned = is_aligned(cmd_rsp.cmd_addr);
  assign accept  = cmd_rsp.cmd_valid && (state_q == IDLE);
  // Only the ack matching the captured direction counts
  assign ack     = write_q ? i_wready : i_rvalid;
  assign cnt_clr = (state_q == REQ);
  assign cnt_en  = (state_q == WAIT) && !ack;

  sfr_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_timeout_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (cnt_clr),
    .enable  (cnt_en),
    .expired (expired)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and state-decoded handshake/strobe outputs
  always_comb begin
    state_d     = state_q;
    cmd_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    wr_en_c     = 1'b0;
    rd_en_c     = 1'b0;
    busy_c      = 1'b1;
    unique case (state_q)
      IDLE: begin
        cmd_ready_c = 1'b1;
        busy_c      = 1'b0;
        if (cmd_rsp.cmd_valid) state_d = aligned ? REQ : RSP;
      end
      REQ: begin
        wr_en_c = write_q;
        rd_en_c = !write_q;
        state_d = WAIT;
      end
      WAIT: if (ack || expired) state_d = RSP;
      RSP: begin
        rsp_valid_c = 1'b1;
        if (cmd_rsp.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command capture, bus address/data hold and response capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      waddr_q   <= '0;
      raddr_q   <= '0;
      wdata_q   <= '0;
      wstrobe_q <= '0;
      rdata_q   <= '0;
      write_q   <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        write_q   <= cmd_rsp.cmd_write;
        err_q     <= !aligned;
        timeout_q <= 1'b0;
        rdata_q   <= '0;
        if (aligned && cmd_rsp.cmd_write) begin
          waddr_q   <= cmd_rsp.cmd_addr;
          wdata_q   <= cmd_rsp.cmd_wdata;
          wstrobe_q <= cmd_rsp.cmd_wstrobe;
        end
        if (aligned && !cmd_rsp.cmd_write) raddr_q <= cmd_rsp.cmd_addr;
      end
      // Ack wins over a same-edge timeout; rdata already zeroed at accept
      if (state_q == WAIT) begin
        if (ack)          rdata_q   <= write_q ? 32'h0 : i_rdata;
        else if (expired) timeout_q <= 1'b1;
      end
    end
  end

  assign cmd_rsp.cmd_ready   = cmd_ready_c;
  assign cmd_rsp.rsp_valid   = rsp_valid_c;
  assign cmd_rsp.rsp_rdata   = rdata_q;
  assign cmd_rsp.rsp_write   = write_q;
  assign cmd_rsp.rsp_timeout = timeout_q;
  assign cmd_rsp.rsp_err     = err_q;
  assign o_wr_en   = wr_en_c;
  assign o_rd_en   = rd_en_c;
  assign o_waddr   = waddr_q;
  assign o_raddr   = raddr_q;
  assign o_wdata   = wdata_q;
  assign o_wstrobe = wstrobe_q;
  assign busy      = busy_c;

endmodule

// File: tb/tb_sfr_bus_initiator.sv
// Bench for sfr_bus_initiator: SFR responder model, table vectors, scoreboard, corner sequences.
module tb_sfr_bus_initiator;

  logic        clk;
  logic        reset_n;
  logic        o_wr_en, o_rd_en, busy;
  logic [31:0] o_waddr, o_raddr, o_wdata;
  logic [3:0]  o_wstrobe;
  logic        i_wready, i_rvalid;
  logic [31:0] i_rdata;

  sfr_bus_initiator_if bus();

  sfr_bus_initiator #(.TIMEOUT_CYCLES(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_rsp   (bus),
    .o_wr_en   (o_wr_en),
    .o_rd_en   (o_rd_en),
    .o_waddr   (o_waddr),
    .o_raddr   (o_raddr),
    .o_wdata   (o_wdata),
    .o_wstrobe (o_wstrobe),
    .i_wready  (i_wready),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int rsp_seen = 0;
  bit in_rsp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- responder: SFR block with programmable ack delay ----------------
  bit          no_wack = 0;
  bit          junk_rvalid = 0;
  int          ack_dly = 0;
  logic        pend, pend_wr;
  logic [1:0]  pend_idx;
  logic [31:0] pend_data;
  logic [3:0]  pend_strb;
  int          wait_left;
  logic [31:0] rmem [4];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend <= 1'b0; pend_wr <= 1'b0; pend_idx <= '0; pend_data <= '0; pend_strb <= '0;
      wait_left <= 0;
      rmem[0] <= 32'h5; rmem[1] <= 32'h0; rmem[2] <= 32'h1; rmem[3] <= 32'h0;
    end else if ((o_wr_en && !no_wack) || o_rd_en) begin
      pend      <= 1'b1;
      pend_wr   <= o_wr_en;
      pend_idx  <= o_wr_en ? o_waddr[3:2] : o_raddr[3:2];
      pend_data <= o_wdata;
      pend_strb <= o_wstrobe;
      wait_left <= ack_dly;
    end else if (pend) begin
      if (wait_left == 0) begin
        pend <= 1'b0;
        if (pend_wr)
          for (int b = 0; b < 4; b++)
            if (pend_strb[b]) rmem[pend_idx][8*b +: 8] <= pend_data[8*b +: 8];
      end else begin
        wait_left <= wait_left - 1;
      end
    end
  end

  assign i_wready = pend && pend_wr && (wait_left == 0);
  assign i_rvalid = (pend && !pend_wr && (wait_left == 0)) || junk_rvalid;
  assign i_rdata  = (pend && !pend_wr) ? rmem[pend_idx] : 32'hDEAD_BEEF;

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    bit          err;
    bit          to;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      in_rsp = 0; wr_cnt = 0; rd_cnt = 0;
    end else begin
      if (bus.cmd_valid && bus.cmd_ready) acc_cyc = cyc;
      if (o_wr_en) wr_cnt++;
      if (o_rd_en) rd_cnt++;
      if (o_wr_en || o_rd_en) chk("wr_rd_exclusive", 32'(o_wr_en & o_rd_en), 32'h0);
      if (bus.rsp_valid) begin
        rsp_seen++;
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_rsp: rsp_valid=1 with nothing outstanding, required 0 (t=%0t)", $time);
        end else begin
          e = sb[0];
          if (!in_rsp) chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
          in_rsp = 1;
          chk("rsp_rdata", bus.rsp_rdata, e.rdata);
          chk("rsp_write", 32'(bus.rsp_write), 32'(e.wr));
          chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.to));
          chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
          chk("cmd_ready_in_rsp", 32'(bus.cmd_ready), 32'h0);
          chk("busy_in_rsp", 32'(busy), 32'h1);
          if (bus.rsp_ready) begin
            void'(sb.pop_front());
            in_rsp = 0;
            chk("wr_pulses", 32'(wr_cnt), 32'(e.wr && !e.err));
            chk("rd_pulses", 32'(rd_cnt), 32'(!e.wr && !e.err));
            if (!e.err && e.wr) begin
              chk("o_waddr", o_waddr, e.addr);
              chk("o_wdata", o_wdata, e.wdata);
              chk("o_wstrobe", 32'(o_wstrobe), 32'(e.strb));
            end
            if (!e.err && !e.wr) chk("o_raddr", o_raddr, e.addr);
            wr_cnt = 0; rd_cnt = 0;
          end
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic send(input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] er, input bit ee,
                      input bit te, input int lat, input bit push);
    exp_t e;
    bit ok;
    ok = 0;
    if (push) begin
      e = '{wr: wr, addr: a, wdata: d, strb: s, rdata: er, err: ee, to: te, lat: lat};
      sb.push_back(e);
    end
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = a;
    bus.cmd_wdata = d; bus.cmd_wstrobe = s;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      ok = bus.cmd_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    chk("cmd_accepted", 32'(ok), 32'h1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    chk("rsp_outstanding", 32'(sb.size()), 32'h0);
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_wr_en", 32'(o_wr_en), 32'h0);
    chk("rst_rd_en", 32'(o_rd_en), 32'h0);
    chk("rst_waddr", o_waddr, 32'h0);
    chk("rst_raddr", o_raddr, 32'h0);
    chk("rst_wdata", o_wdata, 32'h0);
    chk("rst_wstrobe", 32'(o_wstrobe), 32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_write", 32'(bus.rsp_write), 32'h0);
    chk("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'h0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    bit          err;
  } vec_t;
  vec_t vt[10];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen0;
    bit got;
    vt[0] = '{0, 32'h0, 32'h0,         4'h0, 32'h0000_0005, 0};
    vt[1] = '{0, 32'h8, 32'h0,         4'h0, 32'h0000_0001, 0};
    vt[2] = '{1, 32'h4, 32'hA5A5_0001, 4'hF, 32'h0,         0};
    vt[3] = '{0, 32'h4, 32'h0,         4'h0, 32'hA5A5_0001, 0};
    vt[4] = '{1, 32'h8, 32'h1234_5678, 4'h3, 32'h0,         0};
    vt[5] = '{0, 32'h8, 32'h0,         4'h0, 32'h0000_5678, 0};
    vt[6] = '{0, 32'h6, 32'h0,         4'h0, 32'h0,         1};
    vt[7] = '{1, 32'h1, 32'hFFFF_FFFF, 4'hF, 32'h0,         1};
    vt[8] = '{1, 32'h0, 32'hFFFF_FFFF, 4'h4, 32'h0,         0};
    vt[9] = '{0, 32'h0, 32'h0,         4'h0, 32'h00FF_0005, 0};

    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0;
    bus.cmd_wdata = 0; bus.cmd_wstrobe = 0; bus.rsp_ready = 1;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_vals();
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Table: register reads/writes, byte strobes, misaligned rejects
    foreach (vt[i]) begin
      send(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].strb, vt[i].rdata, vt[i].err,
           1'b0, vt[i].err ? 1 : 3, 1'b1);
      wait_done();
    end

    // Write never acked (stray read ack present): timeout after 8 WAIT cycles
    no_wack = 1; junk_rvalid = 1;
    send(1, 32'h0, 32'h1234_5678, 4'hF, 32'h0, 0, 1, 10, 1);
    wait_done();
    no_wack = 0; junk_rvalid = 0;
    send(0, 32'h0, 32'h0, 4'h0, 32'h00FF_0005, 0, 0, 3, 1);
    wait_done();

    // Ack on the same edge the timeout would fire: ack wins
    ack_dly = 7;
    send(1, 32'hC, 32'h1111_2222, 4'hF, 32'h0, 0, 0, 10, 1);
    wait_done();
    ack_dly = 3;
    send(0, 32'hC, 32'h0, 4'h0, 32'h1111_2222, 0, 0, 6, 1);
    wait_done();
    ack_dly = 0;

    // Response back-pressure: fields stable, cmd_ready low, IDLE on handshake edge
    bus.rsp_ready = 0;
    send(0, 32'h8, 32'h0, 4'h0, 32'h0000_5678, 0, 0, 3, 1);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bus.rsp_valid;
    end
    chk("hold_rsp_valid", 32'(got), 32'h1);
    repeat (3) @(posedge clk);
    #1 bus.rsp_ready = 1;
    @(posedge clk); #1;
    chk("hold_idle_busy", 32'(busy), 32'h0);
    chk("hold_idle_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    chk("hold_rsp_popped", 32'(sb.size()), 32'h0);
    sb.delete();

    // Reset while waiting for an ack: immediate reset values, no response
    no_wack = 1;
    send(1, 32'h4, 32'hCAFE_F00D, 4'hF, 32'h0, 0, 0, 0, 0);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = o_wr_en;
    end
    chk("strobe_before_reset", 32'(got), 32'h1);
    repeat (2) @(posedge clk);
    chk("busy_before_reset", 32'(busy), 32'h1);
    seen0 = rsp_seen;
    #3 reset_n = 1'b0;
    #1 check_reset_vals();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1; no_wack = 0;
    repeat (15) @(posedge clk);
    chk("no_rsp_after_reset", 32'(rsp_seen), 32'(seen0));
    #1;
    send(0, 32'h0, 32'h0, 4'h0, 32'h0000_0005, 0, 0, 3, 1);
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
